// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: access-size encodings, word type
// and default data-memory depth.
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam int DEPTH_WORDS_DEFAULT = 256;

endpackage

// File: rtl/mips_load_align.sv
// Little-endian lane select with sign/zero extension for loads; purely
// combinational so it can sit in front of any word-wide storage.
module mips_load_align
    import mips_pkg::*;
(
    input  word_t      i_word,
    input  logic [1:0] i_byte_off,
    input  logic [1:0] i_size,
    input  logic       i_unsigned,
    output word_t      o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_byte_off, 3'b000} +: 8];
    assign w_half = i_word[{i_byte_off[1], 4'b0000} +: 16];

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_data = '0;
        case (size_e'(i_size))
            SZ_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            SZ_WORD: o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mips_data_mem.sv
// Single-cycle data memory: combinational loads, edge-committed stores,
// legality checking with sticky first-fault capture and a store counter.
module mips_data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] rdata_out,
    output logic        fault_out,
    output logic        fault_sticky_out,
    output logic [31:0] fault_addr_out,
    output logic [15:0] store_count_out
);

    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

    word_t             r_mem [DEPTH_WORDS];
    logic              r_fault_sticky;
    logic [31:0]       r_fault_addr;
    logic [15:0]       r_store_count;

    logic [ADDR_W-1:0] w_index;
    word_t             w_word;
    word_t             w_aligned;
    word_t             w_merged;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_fault;
    logic              w_commit;

    assign w_index = addr_in[ADDR_W+1:2];
    assign w_word  = r_mem[w_index];

    assign w_misaligned = ((size_e'(size_in) == SZ_HALF) && addr_in[0]) ||
                          ((size_e'(size_in) == SZ_WORD) && (addr_in[1:0] != 2'b00));
    // Upper address bits do not index the array but must still be in range.
    assign w_out_of_range = (addr_in >= BYTE_LIMIT);

    assign w_fault = (mem_read_in | mem_write_in) &&
                     (w_misaligned || w_out_of_range ||
                      (size_e'(size_in) == SZ_RSVD) ||
                      (mem_read_in && mem_write_in));

    assign w_commit = mem_write_in && !w_fault;

    mips_load_align u_load_align (
        .i_word     (w_word),
        .i_byte_off (addr_in[1:0]),
        .i_size     (size_in),
        .i_unsigned (unsigned_in),
        .o_data     (w_aligned)
    );

    // Sub-word stores rewrite only the selected lane of the addressed word.
    always_comb begin
        w_merged = w_word;
        case (size_e'(size_in))
            SZ_BYTE: w_merged[{addr_in[1:0], 3'b000} +: 8]  = wdata_in[7:0];
            SZ_HALF: w_merged[{addr_in[1], 4'b0000} +: 16]  = wdata_in[15:0];
            SZ_WORD: w_merged                               = wdata_in;
            default: w_merged                               = w_word;
        endcase
    end

    // NOTE: the array is reset word-by-word because a cleared memory after
    // reset is part of the contract; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            // NOTE: non-blocking so same-cycle loads still see pre-edge data.
            r_mem[w_index] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store_count  <= '0;
            r_fault_sticky <= 1'b0;
            r_fault_addr   <= '0;
        end else begin
            if (w_commit) begin
                r_store_count <= r_store_count + 16'd1;
            end
            if (w_fault && !r_fault_sticky) begin
                r_fault_sticky <= 1'b1;
                r_fault_addr   <= addr_in;
            end
        end
    end

    assign fault_out        = w_fault;
    assign rdata_out        = (mem_read_in && !w_fault) ? w_aligned : '0;
    assign fault_sticky_out = r_fault_sticky;
    assign fault_addr_out   = r_fault_addr;
    assign store_count_out  = r_store_count;

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem against a byte-array reference model.
module tb_mips_data_mem;

    localparam int DEPTH_BYTES = 1024;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  size_in;
    logic        unsigned_in;
    logic [31:0] rdata_out;
    logic        fault_out;
    logic        fault_sticky_out;
    logic [31:0] fault_addr_out;
    logic [15:0] store_count_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: memory as a flat little-endian byte array.
    logic [7:0]  m_mem [DEPTH_BYTES];
    logic [15:0] m_count;
    logic        m_sticky;
    logic [31:0] m_faddr;

    mips_data_mem dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .size_in          (size_in),
        .unsigned_in      (unsigned_in),
        .rdata_out        (rdata_out),
        .fault_out        (fault_out),
        .fault_sticky_out (fault_sticky_out),
        .fault_addr_out   (fault_addr_out),
        .store_count_out  (store_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_fault(input bit rd, input bit wr, input logic [1:0] sz,
                                   input logic [31:0] a);
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (a >= 32'(DEPTH_BYTES)) return 1'b1;
        if (a % nbytes(sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a);
        longint v = 0;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) v += longint'(m_mem[a + k]) << (8 * k);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_rdata(input bit rd, input bit wr, input logic [1:0] sz,
                                            input bit uns, input logic [31:0] a);
        if (!rd || m_fault(rd, wr, sz, a)) return 32'h0;
        return m_load(sz, uns, a);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH_BYTES; i++) m_mem[i] = 8'h00;
        m_count  = '0;
        m_sticky = 1'b0;
        m_faddr  = '0;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read_in  = rd;
        mem_write_in = wr;
        size_in      = sz;
        unsigned_in  = uns;
        addr_in      = a;
        wdata_in     = wd;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs held before the edge.
    task automatic tick();
        bit f;
        f = m_fault(mem_read_in, mem_write_in, size_in, addr_in);
        if (mem_write_in && !f) begin
            for (int k = 0; k < nbytes(size_in); k++) m_mem[addr_in + k] = wdata_in[8 * k +: 8];
            m_count = m_count + 16'd1;
        end
        if (f && !m_sticky) begin
            m_sticky = 1'b1;
            m_faddr  = addr_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        m_clear();
        #12;
        n_checks++;
        if (store_count_out !== 16'h0 || fault_sticky_out !== 1'b0 || fault_addr_out !== 32'h0)
            $display("FAIL reset_regs: count=%h sticky=%b faddr=%h required 0/0/0",
                     store_count_out, fault_sticky_out, fault_addr_out);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 2'd2, 0, 32'h0, 32'h0);
        n_checks++;
        if (rdata_out !== 32'h0 || fault_out !== 1'b0)
            $display("FAIL reset_lw0: rdata=%h fault=%b required 00000000/0", rdata_out, fault_out);
        else n_pass++;
    endtask

    task automatic test_subword_loads();
        logic [31:0] exp_s [4];
        logic [31:0] exp_u [4];
        exp_s = '{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88};
        exp_u = '{32'h000000BB, 32'h000000AA, 32'h00000099, 32'h00000088};
        drive(0, 1, 2'd2, 0, 32'h10, 32'h8899AABB);
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int u = 0; u < 2; u++) begin
                drive(1, 0, 2'd0, u[0], 32'h10 + 32'(k), 32'h0);
                n_checks++;
                if (rdata_out !== (u == 1 ? exp_u[k] : exp_s[k]) || fault_out !== 1'b0)
                    $display("FAIL lb_lane%0d_u%0d: rdata=%h fault=%b required %h/0", k, u,
                             rdata_out, fault_out, (u == 1 ? exp_u[k] : exp_s[k]));
                else n_pass++;
            end
        end
        drive(1, 0, 2'd1, 0, 32'h12, 32'h0);
        n_checks++;
        if (rdata_out !== 32'hFFFF8899)
            $display("FAIL lh_0x12: rdata=%h required FFFF8899", rdata_out);
        else n_pass++;
        drive(1, 0, 2'd1, 1, 32'h10, 32'h0);
        n_checks++;
        if (rdata_out !== 32'h0000AABB)
            $display("FAIL lhu_0x10: rdata=%h required 0000AABB", rdata_out);
        else n_pass++;
    endtask

    task automatic test_subword_stores();
        drive(0, 1, 2'd0, 0, 32'h11, 32'hFFFFFF11);
        tick();
        drive(0, 1, 2'd1, 0, 32'h12, 32'hCAFE2233);
        tick();
        drive(1, 0, 2'd2, 0, 32'h10, 32'h0);
        n_checks++;
        if (rdata_out !== 32'h223311BB || store_count_out !== 16'd3)
            $display("FAIL rmw_merge: rdata=%h count=%0d required 223311BB/3",
                     rdata_out, store_count_out);
        else n_pass++;
    endtask

    task automatic test_faults();
        drive(1, 0, 2'd2, 0, 32'h6, 32'h0);
        n_checks++;
        if (fault_out !== 1'b1 || rdata_out !== 32'h0)
            $display("FAIL misaligned_lw: fault=%b rdata=%h required 1/00000000", fault_out, rdata_out);
        else n_pass++;
        tick();
        n_checks++;
        if (fault_sticky_out !== 1'b1 || fault_addr_out !== 32'h6)
            $display("FAIL first_capture: sticky=%b faddr=%h required 1/00000006",
                     fault_sticky_out, fault_addr_out);
        else n_pass++;
        drive(0, 1, 2'd2, 0, 32'h401, 32'h12345678);
        n_checks++;
        if (fault_out !== 1'b1) $display("FAIL sw_0x401: fault=%b required 1", fault_out);
        else n_pass++;
        tick();
        drive(1, 0, 2'd2, 0, 32'h0, 32'h0);
        n_checks++;
        if (rdata_out !== 32'h0 || store_count_out !== 16'd3 || fault_addr_out !== 32'h6)
            $display("FAIL blocked_store: rdata=%h count=%0d faddr=%h required 0/3/6",
                     rdata_out, store_count_out, fault_addr_out);
        else n_pass++;
        drive(1, 0, 2'd0, 0, 32'h400, 32'h0);
        n_checks++;
        if (fault_out !== 1'b1) $display("FAIL range_0x400: fault=%b required 1", fault_out);
        else n_pass++;
        drive(1, 0, 2'd0, 1, 32'h3FF, 32'h0);
        n_checks++;
        if (fault_out !== 1'b0 || rdata_out !== 32'h0)
            $display("FAIL range_0x3ff: fault=%b rdata=%h required 0/0", fault_out, rdata_out);
        else n_pass++;
        drive(1, 0, 2'd3, 0, 32'h10, 32'h0);
        n_checks++;
        if (fault_out !== 1'b1) $display("FAIL reserved_size: fault=%b required 1", fault_out);
        else n_pass++;
        drive(0, 0, 2'd3, 0, 32'hFFFF_FFFF, 32'h0);
        n_checks++;
        if (fault_out !== 1'b0 || rdata_out !== 32'h0)
            $display("FAIL idle_no_fault: fault=%b rdata=%h required 0/0", fault_out, rdata_out);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        drive(1, 0, 2'd2, 0, 32'h20, 32'h0);
        n_checks++;
        if (rdata_out !== 32'h0) $display("FAIL pre_store_read: rdata=%h required 0", rdata_out);
        else n_pass++;
        drive(0, 1, 2'd2, 0, 32'h20, 32'hDEADBEEF);
        n_checks++;
        if (fault_out !== 1'b0 || rdata_out !== 32'h0)
            $display("FAIL store_cycle: fault=%b rdata=%h required 0/0", fault_out, rdata_out);
        else n_pass++;
        tick();
        drive(1, 0, 2'd2, 0, 32'h20, 32'h0);
        n_checks++;
        if (rdata_out !== 32'hDEADBEEF) $display("FAIL post_store_read: rdata=%h required DEADBEEF", rdata_out);
        else n_pass++;
        drive(1, 1, 2'd2, 0, 32'h20, 32'h12345678);
        n_checks++;
        if (fault_out !== 1'b1 || rdata_out !== 32'h0)
            $display("FAIL conflict: fault=%b rdata=%h required 1/0", fault_out, rdata_out);
        else n_pass++;
        tick();
        drive(1, 0, 2'd2, 0, 32'h20, 32'h0);
        n_checks++;
        if (rdata_out !== 32'hDEADBEEF || store_count_out !== m_count)
            $display("FAIL conflict_no_write: rdata=%h count=%0d required DEADBEEF/%0d",
                     rdata_out, store_count_out, m_count);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            int op;
            logic [1:0] sz;
            logic [31:0] a;
            bit rd, wr;
            op = int'($urandom_range(0, 7));
            rd = (op <= 2) || (op == 6);
            wr = (op >= 3 && op <= 6);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~32'(nbytes(sz) - 1);
            drive(rd, wr, sz, $urandom_range(0, 1) == 1, a, $urandom);
            n_checks++;
            if (fault_out !== m_fault(rd, wr, sz, a) ||
                rdata_out !== m_rdata(rd, wr, sz, unsigned_in, a))
                $display("FAIL rand%0d op=%0d sz=%0d a=%h: fault=%b rdata=%h required %b/%h", it, op,
                         sz, a, fault_out, rdata_out, m_fault(rd, wr, sz, a),
                         m_rdata(rd, wr, sz, unsigned_in, a));
            else n_pass++;
            tick();
            n_checks++;
            if (store_count_out !== m_count || fault_sticky_out !== m_sticky || fault_addr_out !== m_faddr)
                $display("FAIL rand%0d_state: count=%0d sticky=%b faddr=%h required %0d/%b/%h", it,
                         store_count_out, fault_sticky_out, fault_addr_out, m_count, m_sticky, m_faddr);
            else n_pass++;
        end
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        #3;
        m_clear();
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            drive(0, 1, 2'd2, 0, 32'h40, 32'(i));
            tick();
            if (i == 65534) begin
                n_checks++;
                if (store_count_out !== 16'hFFFF)
                    $display("FAIL count_ffff: count=%h required FFFF", store_count_out);
                else n_pass++;
            end
        end
        drive(1, 0, 2'd2, 0, 32'h40, 32'h0);
        n_checks++;
        if (store_count_out !== 16'h0000 || rdata_out !== 32'h0000FFFF)
            $display("FAIL count_wrap: count=%h rdata=%h required 0000/0000FFFF", store_count_out, rdata_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        drive(0, 0, 2'd2, 0, 32'h6, 32'h0);
        drive(1, 0, 2'd2, 0, 32'h6, 32'h0);
        tick();
        drive(0, 1, 2'd2, 0, 32'h40, 32'h55AA55AA);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (store_count_out !== 16'h0 || fault_sticky_out !== 1'b0 || fault_addr_out !== 32'h0)
            $display("FAIL async_reset: count=%h sticky=%b faddr=%h required 0/0/0",
                     store_count_out, fault_sticky_out, fault_addr_out);
        else n_pass++;
        @(posedge clk);
        #1;
        m_clear();
        rst_n = 1'b1;
        drive(1, 0, 2'd2, 0, 32'h40, 32'h0);
        n_checks++;
        if (rdata_out !== 32'h0 || store_count_out !== 16'h0)
            $display("FAIL reset_clears: rdata=%h count=%h required 0/0", rdata_out, store_count_out);
        else n_pass++;
        drive(1, 0, 2'd2, 0, 32'h20, 32'h0);
        n_checks++;
        if (rdata_out !== 32'h0) $display("FAIL reset_clears_0x20: rdata=%h required 0", rdata_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_subword_loads();
        test_subword_stores();
        test_faults();
        test_same_cycle();
        test_random();
        test_counter_wrap();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
